// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: self-timed baud tick, 2-flop rx synchroniser,
// mid-bit sampling FSM and a valid/accept holding register with error flags.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_accept,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam logic [SAMP_W-1:0] HALF_CNT  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] FULL_CNT  = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]        LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic              ODD_PAR   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  logic                 rx_meta_q, rxs_q;
  logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                 tick;
  state_e               state_q, state_d;
  logic [SAMP_W-1:0]    samp_cnt_q, samp_cnt_d, samp_next;
  logic                 mid_bit;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fe_pend_q, fe_pend_d;
  logic                 pe_pend_q, pe_pend_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  // Baud tick: count down to zero, then reload; a new divisor lands at reload.
  assign tick       = (tick_cnt_q == '0);
  assign tick_cnt_d = tick ? baud_div : tick_cnt_q - DIV_W'(1);

  // Sample counter wraps every OVERSAMPLE ticks so samples stay at mid-bit.
  assign samp_next = (samp_cnt_q == FULL_CNT) ? '0 : samp_cnt_q + SAMP_W'(1);
  assign mid_bit   = tick && (samp_cnt_q == FULL_CNT);

  // NOTE: every *_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    fe_pend_d  = fe_pend_q;
    pe_pend_d  = pe_pend_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tick && !rxs_q) begin
          state_d    = S_START;
          samp_cnt_d = '0;
          fe_pend_d  = 1'b0;
          pe_pend_d  = 1'b0;
        end
      end

      S_START: begin
        if (tick) begin
          if (samp_cnt_q == HALF_CNT) begin
            // A start bit that is high again by mid-bit was only a glitch.
            if (rxs_q) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_DATA;
              samp_cnt_d = '0;
              bit_cnt_d  = '0;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
      end

      S_DATA: begin
        if (tick) samp_cnt_d = samp_next;
        if (mid_bit) begin
          shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (tick) samp_cnt_d = samp_next;
        if (mid_bit) begin
          pe_pend_d = (rxs_q != ((^shift_q) ^ ODD_PAR));
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (tick) samp_cnt_d = samp_next;
        if (mid_bit) begin
          if (!rxs_q) fe_pend_d = 1'b1;
          if (bit_cnt_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = (fe_pend_q || !rxs_q) ? S_BREAK : S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_BREAK: begin
        if (tick && rxs_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a completion loads if empty or drained this same cycle.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    if (done_q) begin
      if (!rx_valid_q || rx_accept) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        frame_err_d  = fe_pend_q;
        parity_err_d = pe_pend_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_accept) begin
      rx_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      tick_cnt_q   <= baud_div;
      state_q      <= S_IDLE;
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      fe_pend_q    <= 1'b0;
      pe_pend_q    <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rxs_q        <= rx_meta_q;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      fe_pend_q    <= fe_pend_d;
      pe_pend_q    <= pe_pend_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: instance 0 is 8N1, instance 1 adds even parity,
// instance 2 checks two stop bits. Expected frames go through a scoreboard queue.
module tb_uart_rx_os;

  localparam int BIT_CLK = 64;  // baud_div=3 -> tick every 4 clk, 16 ticks/bit

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [2:0]  rx;
  logic [2:0]  rx_accept;
  wire  [7:0]  rx_data [3];
  wire  [2:0]  rx_valid, frame_err, parity_err, overrun_err, busy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx_os #(
      .DATA_BITS (8),
      .OVERSAMPLE(16),
      .DIV_W     (16),
      .PARITY_EN ((g == 1) ? 1 : 0),
      .PARITY_ODD(0),
      .STOP_BITS ((g == 2) ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .baud_div   (baud_div),
      .rx         (rx[g]),
      .rx_data    (rx_data[g]),
      .rx_valid   (rx_valid[g]),
      .rx_accept  (rx_accept[g]),
      .frame_err  (frame_err[g]),
      .parity_err (parity_err[g]),
      .overrun_err(overrun_err[g]),
      .busy       (busy[g])
    );
  end

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ovr_cnt[3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int g = 0; g < 3; g++) begin
        if (overrun_err[g]) ovr_cnt[g]++;
        if (rx_valid[g] && rx_accept[g]) begin
          if (exp_q.size() == 0) begin
            check("spurious_rx_valid", 32'(rx_valid[g]), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("frame_inst", g, e.idx);
            check("rx_data", 32'(rx_data[g]), 32'(e.data));
            check("frame_err", 32'(frame_err[g]), 32'(e.fe));
            check("parity_err", 32'(parity_err[g]), 32'(e.pe));
          end
        end
      end
    end
  end

  task automatic drive_bit(input int g, input logic b, input int clks);
    rx[g] = b;
    repeat (clks) @(negedge clk);
  endtask

  // stops[0] is the first stop bit on the line; hold_low leaves rx low after.
  task automatic send_frame(input int g, input logic [7:0] data, input logic par_bit,
                            input logic [1:0] stops, input logic push, input logic hold_low);
    int   nst;
    logic fe, pe;
    nst = (g == 2) ? 2 : 1;
    fe  = !stops[0] || (nst == 2 && !stops[1]);
    pe  = (g == 1) ? ((^data) != par_bit) : 1'b0;
    if (push) exp_q.push_back('{idx: g, data: data, fe: fe, pe: pe});
    drive_bit(g, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bit(g, data[i], BIT_CLK);
    if (g == 1) drive_bit(g, par_bit, BIT_CLK);
    for (int s = 0; s < nst; s++) drive_bit(g, stops[s], BIT_CLK);
    rx[g] = !hold_low;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      check({tag, "_data"}, 32'(rx_data[g]), 32'd0);
      check({tag, "_ctl"}, {27'd0, rx_valid[g], frame_err[g], parity_err[g],
                            overrun_err[g], busy[g]}, 32'd0);
    end
  endtask

  initial begin
    int ovr0;
    reset     = 1'b1;
    baud_div  = 16'd3;
    rx        = '1;
    rx_accept = '1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 8N1 basic frame
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b1, 1'b0);
    wait_drain("drain_a5", 200);
    repeat (4) @(negedge clk);
    check("busy_after_stop", 32'(busy[0]), 32'd0);
    check("valid_one_cycle", 32'(rx_valid[0]), 32'd0);

    // Even parity: wrong then right parity bit
    send_frame(1, 8'h3C, 1'b1, 2'b11, 1'b1, 1'b0);
    wait_drain("drain_par1", 200);
    send_frame(1, 8'h3C, 1'b0, 2'b11, 1'b1, 1'b0);
    wait_drain("drain_par0", 200);

    // False start: 20 clk low pulse
    rx[0] = 1'b0;
    repeat (20) @(negedge clk);
    rx[0] = 1'b1;
    repeat (100) @(negedge clk);
    check("false_start_busy", 32'(busy[0]), 32'd0);
    check("false_start_valid", 32'(rx_valid[0]), 32'd0);
    check("false_start_flags", {30'd0, frame_err[0], parity_err[0]}, 32'd0);

    // Framing error into a held-low break, then recovery
    send_frame(0, 8'h55, 1'b0, 2'b00, 1'b1, 1'b1);
    repeat (500) @(negedge clk);
    check("break_frame_delivered", exp_q.size(), 0);
    check("busy_in_break", 32'(busy[0]), 32'd1);
    rx[0] = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check("busy_after_break", 32'(busy[0]), 32'd0);
    send_frame(0, 8'h0F, 1'b0, 2'b11, 1'b1, 1'b0);
    wait_drain("drain_0f", 200);

    // Overrun: consumer stalled across two frames
    ovr0 = ovr_cnt[0];
    rx_accept[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b1, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    send_frame(0, 8'h22, 1'b0, 2'b11, 1'b0, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    check("overrun_pulses", ovr_cnt[0] - ovr0, 1);
    check("held_valid", 32'(rx_valid[0]), 32'd1);
    check("held_data", 32'(rx_data[0]), 32'h11);
    rx_accept[0] = 1'b1;
    wait_drain("drain_held", 10);
    @(negedge clk);
    check("valid_after_accept", 32'(rx_valid[0]), 32'd0);

    // Reset in the middle of data bit 4 of 0x99
    drive_bit(0, 1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'(8'h99 >> i), BIT_CLK);
    drive_bit(0, 1'b1, BIT_CLK / 2);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (3) @(negedge clk);
    rx[0] = 1'b1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(0, 8'h42, 1'b0, 2'b11, 1'b1, 1'b0);
    wait_drain("drain_42", 200);

    // Two stop bits: good, then second stop low
    send_frame(2, 8'h5A, 1'b0, 2'b11, 1'b1, 1'b0);
    wait_drain("drain_2stop_ok", 200);
    send_frame(2, 8'h5A, 1'b0, 2'b01, 1'b1, 1'b0);
    wait_drain("drain_2stop_bad", 200);
    repeat (BIT_CLK) @(negedge clk);
    check("busy_2stop_end", 32'(busy[2]), 32'd0);

    check("overrun_inst1", ovr_cnt[1], 0);
    check("overrun_inst2", ovr_cnt[2], 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver, next generation of the team's single-cycle-per-bit RX.
- Generates its own oversample tick from a runtime baud divisor and synchronises the asynchronous rx line.
- Validates the start bit at mid-bit and supports configurable data width, optional parity and 1 or 2 stop bits.
- Delivers each frame through a valid/ready holding register with frame, parity and overrun flags; feeds the UART host-side FIFO.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9.
OVERSAMPLE, 16, ticks per bit period, even, legal 8..32.
DIV_W, 16, width of baud_div.
PARITY_EN, 0, 1 = parity bit present after data.
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
STOP_BITS, 1, stop bits checked, legal 1 or 2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
baud_div  in  DIV_W  clk cycles per oversample tick minus 1
rx  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received data, LSB first on line
rx_valid  out  1  rx_data/flags valid, held until accepted
rx_accept  in  1  consumer ready; transfer when rx_valid & rx_accept
frame_err  out  1  stop bit(s) sampled low, qualified by rx_valid
parity_err  out  1  parity mismatch, qualified by rx_valid; always 0 if PARITY_EN=0
overrun_err  out  1  one-cycle pulse: completed frame dropped
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async): all outputs 0; rx_data 0; FSM IDLE; sync flops to 1; tick counter loaded with baud_div; any frame in progress discarded.
- Sync: 2-flop synchroniser on rx; all logic uses the synchronised signal rxs.
- Tick: down-counter; pulses tick for one clk at 0, then reloads baud_div. baud_div=0 gives a tick every clk. A baud_div change takes effect at the next reload.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on a tick with rxs=0, go to START and clear the sample counter.
- START: at sample count OVERSAMPLE/2-1, sample rxs.
  - rxs=1: false start; return to IDLE, no flags.
  - rxs=0: go to DATA with bit_cnt=0. Subsequent samples occur every OVERSAMPLE ticks, i.e. mid-bit.
- DATA: each sample shifts rxs into MSB of a DATA_BITS shift register (LSB-first line order). After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample; compute even parity of data XOR PARITY_ODD; mismatch sets parity_err_pending. Then go to STOP.
- STOP: sample STOP_BITS bits; any sampled 0 sets frame_err_pending. On the last stop sample the frame completes:
  - Return to IDLE if all stop bits were 1.
  - Go to BREAK otherwise.
- BREAK: wait for rxs=1 sampled on a tick, then IDLE. A held-low line produces no further frames.
- Completion, registered at the cycle after the last stop-bit sample:
  - Holding register empty, or accepted in the same cycle: load rx_data, frame_err, parity_err from the pending values; rx_valid=1. Errored frames are still delivered with flags set.
  - Holding register full and not accepted: new frame dropped; overrun_err=1 for one clk; rx_data/flags/rx_valid unchanged.
- Handshake: rx_valid & rx_accept clears rx_valid next cycle unless a completion loads in that same cycle, in which case rx_valid stays 1 with the new data. rx_data is stable while rx_valid=1 and not accepted.
- Pending error flags clear on entry to START.
- Latency: rx_valid rises 2 clk after the tick of the final stop sample (1 sample register + 1 output register).

Test Plan:
- OVERSAMPLE=16, baud_div=3 (64 clk/bit), rx_accept=1, send 0xA5 8N1 -> rx_valid one cycle, rx_data=0xA5, frame_err=0, parity_err=0, busy low after stop.
- PARITY_EN=1 even, send 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1; resend with parity 0 -> parity_err=0.
- rx low for 20 clk (< half bit), then high -> no rx_valid, busy returns 0, no flags.
- Send 0x55 with stop bit 0, then hold rx low 500 clk -> one frame, rx_data=0x55, frame_err=1; no further frames until rx high; next 0x0F received correctly.
- rx_accept=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun_err one-cycle pulse at second completion; assert rx_accept -> rx_valid drops.
- Assert reset midway through data bit 4 of 0x99 -> all outputs 0, FSM IDLE; next 0x42 received correctly. Also STOP_BITS=2, second stop bit 0 -> frame_err=1.
